// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier:
// controller state encoding and the Booth pair codes for {Q[0],qm1}.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_seq_ctrl.sv
// Booth multiplier control: IDLE/RUN/DONE FSM plus the iteration counter.
// Issues capture (ld), iterate (step) and product-register (fin) strobes.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic ld,
  output logic step,
  output logic fin,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(W + 2);
  localparam logic [CNT_W-1:0] ITER = CNT_W'(W + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last;

  assign last = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ld) begin
      cnt_q <= ITER;
    end else if (step) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // fin fires on the final step so the product lands together with DONE
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          ld      = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            fin     = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, W-bit operands, 2W-bit product.
// Operands are extended to W+1 bits so signed and unsigned share one datapath.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int unsigned E = W + 1;

  logic [E-1:0] a_q, q_q, m_q;
  logic         qm1_q;
  logic [E-1:0] m_ext, q_ext;
  logic [E-1:0] a_sum, a_nx, q_nx;
  logic         qm1_nx;
  logic         ld, step, fin;

  booth_seq_ctrl #(.W(W)) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .ld    (ld),
    .step  (step),
    .fin   (fin),
    .busy  (busy),
    .done  (done)
  );

  assign m_ext = {signed_mode & multiplicand[W-1], multiplicand};
  assign q_ext = {signed_mode & multiplier[W-1], multiplier};

  always_comb begin
    a_sum = a_q;
    unique case ({q_q[0], qm1_q})
      BOOTH_SUB: a_sum = a_q - m_q;
      BOOTH_ADD: a_sum = a_q + m_q;
      default:   a_sum = a_q;
    endcase
    a_nx   = {a_sum[E-1], a_sum[E-1:1]};
    q_nx   = {a_sum[0], q_q[E-1:1]};
    qm1_nx = q_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      qm1_q <= 1'b0;
    end else if (ld) begin
      a_q   <= '0;
      q_q   <= q_ext;
      m_q   <= m_ext;
      qm1_q <= 1'b0;
    end else if (step) begin
      a_q   <= a_nx;
      q_q   <= q_nx;
      qm1_q <= qm1_nx;
    end
  end

  // Low 2W bits of {A,Q} after the last shift; the true product always fits there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
    end else if (fin) begin
      product <= {a_nx[W-2:0], q_nx};
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed cases at W=8 and a
// randomised signed/unsigned sweep at W=16 against an integer product model.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st8, sm8, ab8, busy8, done8;
  logic [7:0]  mc8, mp8;
  logic [15:0] pr8;
  logic        st16, sm16, ab16, busy16, done16;
  logic [15:0] mc16, mp16;
  logic [31:0] pr16;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .signed_mode(sm8),
    .multiplicand(mc8), .multiplier(mp8), .abort(ab8),
    .busy(busy8), .done(done8), .product(pr8)
  );

  booth_mult_seq #(.W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .signed_mode(sm16),
    .multiplicand(mc16), .multiplier(mp16), .abort(ab16),
    .busy(busy16), .done(done16), .product(pr16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Plain integer multiply of the operands interpreted per mode, truncated to 2w bits
  function automatic logic [63:0] ref_mul(input bit s, input int unsigned w,
                                          input logic [31:0] a, input logic [31:0] b);
    longint x, y, r;
    logic [63:0] mask;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    r = x * y;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(r) & mask;
  endfunction

  task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input string tag);
    int unsigned lat, nbusy, ndone;
    sm8 = s; mc8 = a; mp8 = b; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    sm8 = ~s; mc8 = 8'($urandom); mp8 = 8'($urandom);
    lat = 0; ndone = 0; nbusy = busy8 ? 1 : 0;
    while (ndone == 0 && lat < 30) begin
      tick();
      lat++;
      if (busy8) nbusy++;
      if (done8) ndone++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd9);
    chk({tag, "_prod"}, 64'(pr8), 64'(exp));
    chk({tag, "_busy"}, 64'(nbusy), 64'd10);
    tick();
    chk({tag, "_idle"}, {62'd0, busy8, done8}, 64'd0);
  endtask

  task automatic op16(input bit s, input logic [15:0] a, input logic [15:0] b, input string tag);
    int unsigned lat, ndone;
    logic [31:0] exp;
    exp = 32'(ref_mul(s, 16, 32'(a), 32'(b)));
    sm16 = s; mc16 = a; mp16 = b; st16 = 1'b1;
    tick();
    st16 = 1'b0;
    mc16 = 16'($urandom); mp16 = 16'($urandom);
    lat = 0; ndone = 0;
    while (ndone == 0 && lat < 40) begin
      tick();
      lat++;
      if (done16) ndone++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd17);
    chk({tag, "_prod"}, 64'(pr16), 64'(exp));
    tick();
    chk({tag, "_idle"}, {62'd0, busy16, done16}, 64'd0);
  endtask

  initial begin
    int unsigned ndone;
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;
    bit          rs;
    rst_n = 1'b0;
    st8 = 0; sm8 = 0; ab8 = 0; mc8 = '0; mp8 = '0;
    st16 = 0; sm16 = 0; ab16 = 0; mc16 = '0; mp16 = '0;
    tick(); tick();
    chk("rst_u8", {46'd0, busy8, done8, pr8}, 64'd0);
    chk("rst_u16", {30'd0, busy16, done16, pr16}, 64'd0);
    rst_n = 1'b1;
    tick();

    op8(1'b1, 8'hFD, 8'h07, 16'hFFEB, "s_m3x7");
    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ffxff");
    op8(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_ffxff");
    op8(1'b1, 8'h80, 8'h80, 16'h4000, "s_80x80");
    op8(1'b1, 8'h80, 8'h7F, 16'hC080, "s_80x7f");

    // start while busy is ignored
    sm8 = 1; mc8 = 8'd5; mp8 = 8'd6; st8 = 1;
    tick();
    st8 = 0;
    tick(); tick(); tick();
    mc8 = 8'd9; mp8 = 8'd9; st8 = 1;
    tick();
    st8 = 0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done8) ndone++;
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);
    chk("busy_start_prod", 64'(pr8), 64'h001E);

    // abort mid-run
    mc8 = 8'd12; mp8 = 8'd12; st8 = 1;
    tick();
    st8 = 0;
    tick(); tick();
    ab8 = 1;
    tick();
    ab8 = 0;
    chk("abort_busy", 64'(busy8), 64'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) ndone++;
    end
    chk("abort_ndone", 64'(ndone), 64'd0);
    chk("abort_prod", 64'(pr8), 64'h001E);

    // start with abort in IDLE is refused
    st8 = 1; ab8 = 1;
    tick();
    st8 = 0; ab8 = 0;
    chk("startabort_busy", 64'(busy8), 64'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) ndone++;
    end
    chk("startabort_ndone", 64'(ndone), 64'd0);
    chk("startabort_prod", 64'(pr8), 64'h001E);

    // async reset mid-operation
    mc8 = 8'd7; mp8 = 8'd9; st8 = 1;
    tick();
    st8 = 0;
    for (int i = 0; i < 5; i++) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_state", {46'd0, busy8, done8, pr8}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    op8(1'b1, 8'd2, 8'd3, 16'h0006, "after_rst");

    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      op8(rs, ra, rb, 16'(ref_mul(rs, 8, 32'(ra), 32'(rb))), "rnd8");
    end

    op16(1'b1, 16'h8000, 16'h8000, "w16_minmin");
    op16(1'b0, 16'hFFFF, 16'hFFFF, "w16_umax");
    op16(1'b1, 16'h8000, 16'h7FFF, "w16_minmax");
    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom);
      wa = 16'($urandom);
      wb = 16'($urandom);
      op16(rs, wa, wb, "rnd16");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
